exe_result_mux: RTL
===================

Name: exe_result_mux

Overview:
- Parametrised EXE-stage result selector plus EXE/MEM result register.
- Generalises the two-way ALU/CSR result select to NUM_SRC sources, for example ALU, CSR read, PC+4 and MUL/DIV.
- Sources flagged in MC_MASK are multi-cycle. While such a source is pending, the block stalls the front of the pipe until that source signals done.
- Output is registered; it has a valid bit and honours downstream stall and pipeline flush.

Parameters:
- DATA_W, 32, width of each source and of the result.
- NUM_SRC, 4, number of result sources (2..16).
- SEL_W, $clog2(NUM_SRC), width of the select; derived, do not override.
- MC_MASK, 4'b1000, bit i = 1 marks source i as multi-cycle. Width is NUM_SRC.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  EXE stage holds a valid instruction this cycle.
- src_sel  in  SEL_W  index of the source whose data becomes the result.
- src_data  in  NUM_SRC*DATA_W  packed source data; source i occupies [i*DATA_W +: DATA_W].
- src_done  in  NUM_SRC  completion flags. Only bits set in MC_MASK are used; the others are ignored.
- stall_in  in  1  downstream (MEM) stall; output register must hold.
- flush  in  1  pipeline flush (branch or trap).
- out_valid  out  1  out_data is valid for MEM.
- out_data  out  DATA_W  registered result.
- busy  out  1  combinational; asks upstream to hold the EXE instruction.
- sel_err  out  1  registered one-cycle pulse: an accepted src_sel was >= NUM_SRC.

Behaviour:
- Reset (async, rst=1):
  - out_valid=0, out_data=0, sel_err=0.
  - state=IDLE, sel_q=0.
  - Reset asserted mid-wait abandons the pending operation.
- States: IDLE, WAIT_MC.
- Definitions:
  - mc = MC_MASK[src_sel].
  - accept = in_valid & !stall_in & !flush & state==IDLE & (!mc | src_done[src_sel]).
- IDLE, on each rising edge:
  - If accept: out_data <= src_data[src_sel], out_valid <= 1. Latency is one cycle.
  - If in_valid & mc & !src_done[src_sel] & !stall_in & !flush: go to WAIT_MC and set sel_q <= src_sel. out_valid <= 0.
  - Else if !stall_in: out_valid <= 0. out_data holds its last value.
- WAIT_MC:
  - If flush: go to IDLE, out_valid <= 0.
  - Else if src_done[sel_q] & !stall_in: out_data <= src_data[sel_q], out_valid <= 1, go to IDLE.
  - Otherwise remain in WAIT_MC, out_valid <= 0 (bubble to MEM).
  - A multi-cycle source holds src_done and its data until the cycle after busy falls.
- busy = stall_in | (state==WAIT_MC & !(src_done[sel_q] & !flush)) | (state==IDLE & in_valid & mc & !src_done[src_sel] & !flush).
  - busy never depends on out_* registers, so there is no combinational loop.
- stall_in: out_valid and out_data hold exactly; no state transition from IDLE.
  - flush overrides stall.
- flush: out_valid <= 0 next edge, regardless of stall_in. sel_err is not raised. flush is inactive during reset.
- Out-of-range select (NUM_SRC not a power of 2, src_sel >= NUM_SRC, accepted in IDLE):
  - out_data <= 0, out_valid <= 1, sel_err <= 1 for one cycle.
  - Treated as single-cycle.
- Done flag on a non-MC source: ignored.
- src_done[sel] already high in IDLE: zero-wait capture, no WAIT_MC entry.
- Back-to-back accepts produce one result per cycle with no bubbles.

Test Plan:
1. NUM_SRC=4 (DATA_W=32), src_sel=0, src_data[0]=32'h0000_1234, in_valid=1 for 3 cycles with sel 0,1,2 (data 0x1234/0xCAFE_0001/0x8) -> out_valid=1 each cycle one cycle later, out_data 0x1234, 0xCAFE_0001, 0x8; busy=0 throughout.
2. src_sel=3 (MC), src_done[3]=0 for 5 cycles then 1 with data 0xDEAD_BEEF -> busy=1 for 5 cycles, out_valid=0 during wait, out_valid=1 and out_data=0xDEAD_BEEF on the edge after done, state back to IDLE.
3. Result 0x55 valid, then stall_in=1 for 3 cycles with new in_valid/src_data[0]=0x66 -> out_data stays 0x55, out_valid stays 1, busy=1; after stall drops, 0x66 appears one cycle later.
4. WAIT_MC on source 3, flush=1 for one cycle (with src_done[3]=1 same cycle) -> out_valid=0 next edge, state=IDLE, busy=0 after flush, no 0xDEAD_BEEF output.
5. NUM_SRC=3 instance, src_sel=3 accepted -> out_data=0, out_valid=1, sel_err pulses exactly one cycle.
6. rst asserted asynchronously mid-WAIT_MC and mid-valid output -> out_valid=0, out_data=0, sel_err=0 immediately (before next clk edge); first post-reset accept of sel 0 gives the correct result.

Source files
------------

// File: rtl/exe_result_mux.sv
// EXE-stage result selector with EXE/MEM result register.
// Multi-cycle sources park the block in WAIT_MC until their done flag rises.
module exe_result_mux #(
    parameter int                 DATA_W  = 32,
    parameter int                 NUM_SRC = 4,
    parameter int                 SEL_W   = $clog2(NUM_SRC),
    parameter logic [NUM_SRC-1:0] MC_MASK = {1'b1, {(NUM_SRC-1){1'b0}}}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [SEL_W-1:0]          src_sel,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_done,
    input  logic                      stall_in,
    input  logic                      flush,
    output logic                      out_valid,
    output logic [DATA_W-1:0]         out_data,
    output logic                      busy,
    output logic                      sel_err
);

    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] WAIT_MC = 1'b1;

    logic [0:0]        state;
    logic [SEL_W-1:0]  sel_q;

    logic [DATA_W-1:0] sel_data;
    logic              sel_mc;
    logic              sel_done;
    logic              sel_ok;
    logic [DATA_W-1:0] q_data;
    logic              q_done;

    // Out-of-range selects fall through with zero data and no MC flag.
    always_comb begin
        sel_data = '0;
        sel_mc   = 1'b0;
        sel_done = 1'b0;
        sel_ok   = 1'b0;
        q_data   = '0;
        q_done   = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_sel == SEL_W'(i)) begin
                sel_data = src_data[i*DATA_W +: DATA_W];
                sel_mc   = MC_MASK[i];
                sel_done = src_done[i];
                sel_ok   = 1'b1;
            end
            if (sel_q == SEL_W'(i)) begin
                q_data = src_data[i*DATA_W +: DATA_W];
                q_done = src_done[i];
            end
        end
    end

    logic idle;
    logic mc_pending;
    logic accept;
    logic go_wait;

    assign idle       = (state == IDLE);
    assign mc_pending = in_valid & sel_mc & ~sel_done;
    assign accept     = idle & in_valid & ~stall_in & ~flush
                      & (~sel_mc | sel_done);
    assign go_wait    = idle & mc_pending & ~stall_in & ~flush;

    assign busy = stall_in
                | (~idle & ~(q_done & ~flush))
                | (idle & mc_pending & ~flush);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sel_err   <= 1'b0;
        end else begin
            sel_err <= accept & ~sel_ok;
            if (idle) begin
                if (flush) begin
                    out_valid <= 1'b0;
                end else if (accept) begin
                    out_data  <= sel_data;
                    out_valid <= 1'b1;
                end else if (go_wait) begin
                    state     <= WAIT_MC;
                    sel_q     <= src_sel;
                    out_valid <= 1'b0;
                end else if (!stall_in) begin
                    out_valid <= 1'b0;
                end
            end else begin
                if (flush) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end else if (q_done && !stall_in) begin
                    state     <= IDLE;
                    out_data  <= q_data;
                    out_valid <= 1'b1;
                end else if (!stall_in) begin
                    out_valid <= 1'b0;
                end
            end
        end
    end

endmodule
